// File: rtl/extcall_log_streamer.sv
// extcall_log_streamer: frames hypercall log requests onto an AXI4-Stream master.
// Packet = header {type, code}, level tryte, then the NUL-terminated string read
// one tryte at a time from data memory, buffered through a small output FIFO.
//
// state | meaning
// IDLE  | waiting for a request strobe
// HDR   | push header word
// LVL   | push level word (final word for an exit request)
// REQ   | issue one memory read once the FIFO has room
// WAIT  | wait for the read response, push the tryte
// TERM  | push forced zero terminator after hitting the length limit
// ABORT | push all-ones fault word
// DRAIN | wait until the last word has left the FIFO
// DONE  | completion pulse with flags
module extcall_log_streamer #(
  parameter int          P_TDATA_WIDTH = 32,
  parameter int          P_FIFO_DEPTH  = 8,
  parameter int          P_MAX_LEN     = 256,
  parameter int          P_TLAST_MODE  = 0,
  parameter logic [5:0]  P_EXIT_CODE   = 6'd0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_enable,
  input  logic                     i_type,
  input  logic [5:0]               i_code,
  input  logic [17:0]              i_level,
  input  logic [17:0]              i_ptr,
  output logic                     o_ready,
  output logic                     o_pagefault,
  output logic                     o_exit,
  output logic                     mem_e,
  output logic [17:0]              mem_addr,
  output logic [1:0]               mem_pt,
  input  logic [17:0]              mem_rdata,
  input  logic                     mem_valid,
  input  logic                     mem_fault,
  output logic [P_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int IW = $clog2(P_MAX_LEN + 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(P_FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(P_MAX_LEN - 1);

  typedef enum logic [3:0] {
    IDLE, HDR, LVL, REQ, WAIT, TERM, ABORT, DRAIN, DONE
  } state_t;

  state_t state;

  logic        type_q;
  logic [5:0]  code_q;
  logic [17:0] level_q;
  logic [17:0] ptr_q;
  logic [IW-1:0] idx;
  logic        fault_flag;
  logic        is_exit;

  logic [P_TDATA_WIDTH-1:0] fifo_data [P_FIFO_DEPTH];
  logic                     fifo_last [P_FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count;
  logic                     full, pop, can_push;

  logic                     push;
  logic [P_TDATA_WIDTH-1:0] push_data;
  logic                     push_last;

  assign is_exit  = type_q && (code_q == P_EXIT_CODE);
  assign full     = (count == DEPTH_C);
  assign pop      = m_axis_tvalid && m_axis_tready;
  // A full FIFO can still accept a word in the same cycle one leaves it.
  assign can_push = !full || pop;
  assign mem_pt   = 2'b01;

  assign m_axis_tvalid = (count != '0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && ((P_TLAST_MODE == 0) ? 1'b1 : fifo_last[rd_ptr]);

  // Select the word the FSM offers to the FIFO in the current state.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    push_last = 1'b0;
    case (state)
      HDR: begin
        push      = can_push;
        push_data = P_TDATA_WIDTH'({type_q, code_q});
      end
      LVL: begin
        push      = can_push;
        push_data = P_TDATA_WIDTH'(level_q);
        push_last = is_exit;
      end
      WAIT: begin
        // REQ only issues a read with room to spare, so this push always fits.
        push      = mem_valid && !mem_fault;
        push_data = P_TDATA_WIDTH'(mem_rdata);
        push_last = (mem_rdata == 18'd0);
      end
      TERM: begin
        push      = can_push;
        push_last = 1'b1;
      end
      ABORT: begin
        push      = can_push;
        push_data = '1;
        push_last = 1'b1;
      end
      default: ;
    endcase
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < P_FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= push_last;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Request sequencing FSM with registered memory strobe and completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      type_q      <= 1'b0;
      code_q      <= '0;
      level_q     <= '0;
      ptr_q       <= '0;
      idx         <= '0;
      fault_flag  <= 1'b0;
      mem_e       <= 1'b0;
      mem_addr    <= '0;
      o_ready     <= 1'b0;
      o_pagefault <= 1'b0;
      o_exit      <= 1'b0;
    end else begin
      mem_e       <= 1'b0;
      o_ready     <= 1'b0;
      o_pagefault <= 1'b0;
      o_exit      <= 1'b0;
      case (state)
        IDLE: if (i_enable) begin
          type_q     <= i_type;
          code_q     <= i_code;
          level_q    <= i_level;
          ptr_q      <= i_ptr;
          idx        <= '0;
          fault_flag <= 1'b0;
          state      <= HDR;
        end
        HDR: if (push) state <= LVL;
        LVL: if (push) state <= is_exit ? DRAIN : REQ;
        REQ: if (!full) begin
          mem_e    <= 1'b1;
          mem_addr <= ptr_q + 18'(idx);
          state    <= WAIT;
        end
        WAIT: if (mem_valid) begin
          if (mem_fault)              state <= ABORT;
          else if (mem_rdata == 18'd0) state <= DRAIN;
          else if (idx == LAST_IDX)   state <= TERM;
          else begin
            idx   <= idx + 1'b1;
            state <= REQ;
          end
        end
        TERM: if (push) state <= DRAIN;
        ABORT: if (push) begin
          fault_flag <= 1'b1;
          state      <= DRAIN;
        end
        // Complete in the cycle right after the last word is accepted.
        DRAIN: if (count == '0 || (count == (AW + 1)'(1) && pop)) begin
          o_ready     <= 1'b1;
          o_pagefault <= fault_flag;
          o_exit      <= is_exit;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extcall_log_streamer.sv
// Bench for extcall_log_streamer: two instances (A: mode 0, depth 2, max len 4;
// B: mode 1, depth 8, max len 256) share stimulus; sel picks the active one.
module tb_extcall_log_streamer;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        en_a, en_b;
  logic        i_type;
  logic [5:0]  i_code;
  logic [17:0] i_level, i_ptr;
  logic [17:0] mem_rdata;
  logic        mem_valid, mem_fault, tready;

  logic          a_ready, a_pf, a_exit, a_me, a_tlast, a_tvalid;
  logic [17:0]   a_addr;
  logic [1:0]    a_pt;
  logic [W-1:0]  a_tdata;
  logic          b_ready, b_pf, b_exit, b_me, b_tlast, b_tvalid;
  logic [17:0]   b_addr;
  logic [1:0]    b_pt;
  logic [W-1:0]  b_tdata;

  extcall_log_streamer #(.P_TDATA_WIDTH(W), .P_FIFO_DEPTH(2), .P_MAX_LEN(4),
                         .P_TLAST_MODE(0), .P_EXIT_CODE(6'd0)) dut_a (
    .clk(clk), .rst(rst), .i_enable(en_a), .i_type(i_type), .i_code(i_code),
    .i_level(i_level), .i_ptr(i_ptr), .o_ready(a_ready), .o_pagefault(a_pf),
    .o_exit(a_exit), .mem_e(a_me), .mem_addr(a_addr), .mem_pt(a_pt),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid && !sel), .mem_fault(mem_fault),
    .m_axis_tdata(a_tdata), .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(tready));

  extcall_log_streamer #(.P_TDATA_WIDTH(W), .P_FIFO_DEPTH(8), .P_MAX_LEN(256),
                         .P_TLAST_MODE(1), .P_EXIT_CODE(6'd0)) dut_b (
    .clk(clk), .rst(rst), .i_enable(en_b), .i_type(i_type), .i_code(i_code),
    .i_level(i_level), .i_ptr(i_ptr), .o_ready(b_ready), .o_pagefault(b_pf),
    .o_exit(b_exit), .mem_e(b_me), .mem_addr(b_addr), .mem_pt(b_pt),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid && sel), .mem_fault(mem_fault),
    .m_axis_tdata(b_tdata), .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(tready));

  wire         o_ready  = sel ? b_ready  : a_ready;
  wire         o_pf     = sel ? b_pf     : a_pf;
  wire         o_exit   = sel ? b_exit   : a_exit;
  wire         mem_e    = sel ? b_me     : a_me;
  wire [17:0]  mem_addr = sel ? b_addr   : a_addr;
  wire [1:0]   mem_pt   = sel ? b_pt     : a_pt;
  wire [W-1:0] tdata    = sel ? b_tdata  : a_tdata;
  wire         tlast    = sel ? b_tlast  : a_tlast;
  wire         tvalid   = sel ? b_tvalid : a_tvalid;

  typedef struct packed { logic [W-1:0] d; logic l; } word_t;
  word_t        exp_q[$];
  logic [17:0]  exp_addr[$];
  logic [1:0]   exp_done[$];
  logic [W-1:0] got_q[$];
  logic [17:0]  mem_arr [logic [17:0]];
  logic         fault_en;
  logic [17:0]  fault_addr;

  int total = 0, bad = 0;
  int cyc = 0, en_cyc = 0, last_acc = 0, done_cnt = 0;
  int rd_idx = 0, acc_pkt = 0, lat = 1, bp = 0;
  bit first_pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] rd_mem(input logic [17:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : 18'd0;
  endfunction

  // Reference: list every word, read address and completion flag a request must produce.
  task automatic build_expect(input bit s, input logic t, input logic [5:0] c,
                              input logic [17:0] lvl, input logic [17:0] p);
    bit          mode1 = s;
    int          maxl  = s ? 256 : 4;
    logic [17:0] a, v;
    exp_q.push_back('{W'({t, c}), !mode1});
    if (t && c == 6'd0) begin
      exp_q.push_back('{W'(lvl), 1'b1});
      exp_done.push_back(2'b01);
      return;
    end
    exp_q.push_back('{W'(lvl), !mode1});
    for (int i = 0; i < 300; i++) begin
      a = 18'((int'(p) + i) % 262144);
      exp_addr.push_back(a);
      if (fault_en && a == fault_addr) begin
        exp_q.push_back('{{W{1'b1}}, 1'b1});
        exp_done.push_back(2'b10);
        return;
      end
      v = rd_mem(a);
      exp_q.push_back('{W'(v), !mode1 || v == 18'd0});
      if (v == 18'd0) begin
        exp_done.push_back(2'b00);
        return;
      end
      if (i + 1 == maxl) begin
        exp_q.push_back('{W'(0), 1'b1});
        exp_done.push_back(2'b00);
        return;
      end
    end
  endtask

  // Memory responder: one response per strobe after lat cycles.
  initial begin
    int pend = 0;
    logic [17:0] paddr = '0;
    mem_valid = 0; mem_fault = 0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = 0; mem_fault = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mem_valid = 1;
          mem_rdata = rd_mem(paddr);
          mem_fault = fault_en && paddr == fault_addr;
        end
      end
      if (mem_e) begin
        pend  = lat;
        paddr = mem_addr;
      end
    end
  end

  // Stream sink ready pattern.
  initial begin
    int tc = 0;
    tready = 1;
    forever begin
      @(posedge clk); #1;
      tc++;
      tready = (bp != 0) ? (tc % 3 == 0) : 1'b1;
    end
  end

  // Per-cycle comparison against the reference queues.
  initial begin
    bit prev_stall = 0;
    logic [W-1:0] prev_d = '0;
    logic prev_l = 0;
    word_t w;
    int depth;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); exp_addr.delete(); exp_done.delete();
        prev_stall = 0; first_pend = 0;
        continue;
      end
      depth = sel ? 8 : 2;
      if (!o_ready) chk("flags_idle", {o_pf, o_exit}, 2'b00);
      if (prev_stall) chk("stall_stable", {tvalid, tlast, tdata}, {1'b1, prev_l, prev_d});
      if (tvalid && first_pend) begin
        chk("first_latency", cyc, en_cyc + 2);
        first_pend = 0;
      end
      if (mem_e) begin
        chk("mem_pt", mem_pt, 2'b01);
        chk("read_when_full", (2 + rd_idx - acc_pkt) < depth, 1'b1);
        if (exp_addr.size() == 0) chk("extra_read", mem_addr, 64'hDEAD);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
        rd_idx++;
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) chk("extra_word", tdata, 64'hDEAD);
        else begin
          w = exp_q.pop_front();
          chk("tdata", tdata, w.d);
          chk("tlast", tlast, w.l);
        end
        got_q.push_back(tdata);
        last_acc = cyc;
        acc_pkt++;
      end
      if (o_ready) begin
        if (exp_done.size() == 0) chk("extra_ready", o_ready, 1'b0);
        else chk("done_flags", {o_pf, o_exit}, exp_done.pop_front());
        chk("ready_latency", cyc, last_acc + 1);
        chk("words_left", exp_q.size(), 0);
        done_cnt++;
      end
      prev_stall = tvalid && !tready;
      prev_d = tdata;
      prev_l = tlast;
    end
  end

  task automatic start_req(input bit s, input logic t, input logic [5:0] c,
                           input logic [17:0] lvl, input logic [17:0] p);
    @(posedge clk); #1;
    sel = s;
    build_expect(s, t, c, lvl, p);
    got_q.delete();
    rd_idx = 0; acc_pkt = 0;
    i_type = t; i_code = c; i_level = lvl; i_ptr = p;
    if (s) en_b = 1; else en_a = 1;
    en_cyc = cyc;
    first_pend = 1;
    @(posedge clk); #1;
    en_a = 0; en_b = 0;
  endtask

  task automatic run_req(input bit s, input logic t, input logic [5:0] c,
                         input logic [17:0] lvl, input logic [17:0] p);
    int n = done_cnt;
    int k = 0;
    start_req(s, t, c, lvl, p);
    while (done_cnt == n && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("completion_seen", done_cnt, n + 1);
    chk("reads_left", exp_addr.size(), 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst = 1; sel = 0; en_a = 0; en_b = 0;
    i_type = 0; i_code = '0; i_level = '0; i_ptr = '0;
    fault_en = 0; fault_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast",  tlast, 1'b0);
    chk("rst_tdata",  tdata, '0);
    chk("rst_ready",  {o_ready, o_pf, o_exit}, 3'b000);
    chk("rst_mem",    {mem_e, mem_addr}, '0);
    @(posedge clk); #1 rst = 0;

    // "Hi" in mode 0
    mem_arr[18'h5D53] = 18'h48;
    mem_arr[18'h5D54] = 18'h69;
    mem_arr[18'h5D55] = 18'h0;
    run_req(0, 1'b1, 6'h01, 18'd3, 18'h5D53);
    chk("hi_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      chk("hi_w0", got_q[0], 32'h41);
      chk("hi_w1", got_q[1], 32'h3);
      chk("hi_w2", got_q[2], 32'h48);
      chk("hi_w3", got_q[3], 32'h69);
      chk("hi_w4", got_q[4], 32'h0);
    end

    // same request in mode 1, slower memory
    lat = 3;
    run_req(1, 1'b1, 6'h01, 18'd3, 18'h5D53);

    // backpressure on the depth-2 instance
    mem_arr[18'h0040] = 18'h78;
    mem_arr[18'h0041] = 18'h79;
    mem_arr[18'h0042] = 18'h7A;
    mem_arr[18'h0043] = 18'h0;
    lat = 2; bp = 1;
    run_req(0, 1'b1, 6'h01, 18'd5, 18'h0040);
    bp = 0;

    // page fault on the second read
    mem_arr[18'h0100] = 18'h41;
    fault_en = 1; fault_addr = 18'h0101; lat = 1;
    run_req(1, 1'b1, 6'h01, 18'd1, 18'h0100);
    chk("pf_count", got_q.size(), 4);
    if (got_q.size() == 4) chk("pf_word", got_q[3], 32'hFFFFFFFF);
    fault_en = 0;

    // unterminated string hits the length limit of 4
    for (int i = 0; i < 6; i++) mem_arr[18'h0200 + 18'(i)] = 18'(i + 1);
    run_req(0, 1'b1, 6'h01, 18'd2, 18'h0200);
    chk("max_count", got_q.size(), 7);
    if (got_q.size() == 7) begin
      chk("max_w5", got_q[5], 32'h4);
      chk("max_w6", got_q[6], 32'h0);
    end

    // address wraps past the top of the 18-bit space
    mem_arr[18'h3FFFE] = 18'h61;
    mem_arr[18'h3FFFF] = 18'h62;
    mem_arr[18'h00000] = 18'h0;
    run_req(1, 1'b1, 6'h02, 18'd4, 18'h3FFFE);

    // exit request: header and level only
    run_req(0, 1'b1, 6'h00, 18'd7, 18'h5D53);
    chk("exit_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("exit_hdr", got_q[0], 32'h40);

    // reset in the middle of a long packet
    for (int i = 0; i < 12; i++) mem_arr[18'h0300 + 18'(i)] = 18'h21;
    mem_arr[18'h030C] = 18'h0;
    lat = 3;
    start_req(1, 1'b1, 6'h01, 18'd2, 18'h0300);
    repeat (7) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("tvalid_after_rst", tvalid, 1'b0);
    repeat (6) @(posedge clk);
    lat = 1;
    run_req(1, 1'b1, 6'h01, 18'd3, 18'h5D53);
    chk("post_rst_count", got_q.size(), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
